// File: rtl/rs_sched.sv
// rs_sched - reservation-station entry allocation and dispatch scheduler.
//
// Owns the RS busy bitmap. On issue it hands the decoder the lowest free entry.
// Each cycle it round-robin selects one busy, operand-ready entry into a
// registered dispatch slot toward EX, using valid/ready backpressure.
// A flush (branch mispredict) clears every entry and the dispatch slot.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-low
//   rdy        in   1        global enable; low freezes all state
//   alloc_req  in   1        decoder writes an instruction into alloc_idx
//   alloc_ok   out  1        a free entry exists, rdy=1 and no flush
//   alloc_idx  out  IDX_W    lowest-numbered free entry (0 when full)
//   ready_vec  in   RS_SIZE  per-entry "both operands valid"
//   ex_ready   in   1        EX accepts disp_idx this cycle
//   disp_valid out  1        registered: the slot holds a dispatched entry
//   disp_idx   out  IDX_W    registered: entry index presented to EX
//   flush      in   1        synchronous clear of all entries and the slot
//   busy_vec   out  RS_SIZE  registered busy bitmap
//   count      out  IDX_W+1  registered number of busy entries
//   full       out  1        count == RS_SIZE
module rs_sched #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               alloc_req,
    output logic               alloc_ok,
    output logic [IDX_W-1:0]   alloc_idx,
    input  logic [RS_SIZE-1:0] ready_vec,
    input  logic               ex_ready,
    output logic               disp_valid,
    output logic [IDX_W-1:0]   disp_idx,
    input  logic               flush,
    output logic [RS_SIZE-1:0] busy_vec,
    output logic [IDX_W:0]     count,
    output logic               full
);

    localparam logic [IDX_W:0]     FULL_CNT = (IDX_W+1)'(RS_SIZE);
    localparam logic [RS_SIZE-1:0] ONE_HOT0 = {{(RS_SIZE-1){1'b0}}, 1'b1};

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [RS_SIZE-1:0] vec);
        logic [IDX_W-1:0] idx_v;
        idx_v = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            idx_v = vec[i] ? IDX_W'(i) : idx_v;
        end
        return idx_v;
    endfunction

    logic [RS_SIZE-1:0] busy_r;
    logic [IDX_W:0]     count_r;
    logic               disp_valid_r;
    logic [IDX_W-1:0]   disp_idx_r;
    logic [IDX_W-1:0]   rr_ptr_r;

    logic [RS_SIZE-1:0] free_s;
    logic               any_free_s;
    logic               alloc_ok_s;
    logic [IDX_W-1:0]   alloc_idx_s;
    logic               alloc_fire_s;
    logic [RS_SIZE-1:0] alloc_mask_s;
    logic [RS_SIZE-1:0] cand_s;
    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               load_s;
    logic               disp_fire_s;
    logic [RS_SIZE-1:0] disp_mask_s;
    logic [RS_SIZE-1:0] busy_nxt_s;
    logic [IDX_W:0]     count_nxt_s;

    // Free-entry lookup and the allocation handshake toward the decoder.
    always_comb begin
        free_s       = ~busy_r;
        any_free_s   = |free_s;
        alloc_idx_s  = lowest_set(free_s);
        alloc_ok_s   = any_free_s & rdy & ~flush;
        alloc_fire_s = alloc_req & alloc_ok_s;
        if (alloc_fire_s) begin
            alloc_mask_s = ONE_HOT0 << alloc_idx_s;
        end else begin
            alloc_mask_s = {RS_SIZE{1'b0}};
        end
    end

    // Round-robin winner: first busy and ready entry at or after rr_ptr, with wrap.
    always_comb begin
        logic [IDX_W-1:0] scan_idx_v;
        scan_idx_v  = {IDX_W{1'b0}};
        cand_s      = busy_r & ready_vec;
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            // IDX_W-bit addition wraps modulo RS_SIZE (power of two).
            scan_idx_v  = rr_ptr_r + IDX_W'(i);
            win_idx_s   = (!win_found_s && cand_s[scan_idx_v]) ? scan_idx_v : win_idx_s;
            win_found_s = win_found_s | cand_s[scan_idx_v];
        end
    end

    // Slot reload decision and next busy bitmap / occupancy.
    always_comb begin
        // The slot may take a new entry when empty or when EX drains it this cycle.
        load_s      = ~disp_valid_r | ex_ready;
        disp_fire_s = load_s & win_found_s;
        if (disp_fire_s) begin
            disp_mask_s = ONE_HOT0 << win_idx_s;
        end else begin
            disp_mask_s = {RS_SIZE{1'b0}};
        end
        // Alloc targets a free entry and dispatch a busy one, so the masks never overlap.
        busy_nxt_s  = (busy_r | alloc_mask_s) & ~disp_mask_s;
        count_nxt_s = count_r + (IDX_W+1)'(alloc_fire_s) - (IDX_W+1)'(disp_fire_s);
    end

    // State registers: busy bitmap, occupancy, dispatch slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= {RS_SIZE{1'b0}};
            count_r      <= {(IDX_W+1){1'b0}};
            disp_valid_r <= 1'b0;
            disp_idx_r   <= {IDX_W{1'b0}};
            rr_ptr_r     <= {IDX_W{1'b0}};
        end else if (rdy) begin
            if (flush) begin
                busy_r       <= {RS_SIZE{1'b0}};
                count_r      <= {(IDX_W+1){1'b0}};
                disp_valid_r <= 1'b0;
                disp_idx_r   <= disp_idx_r;
                rr_ptr_r     <= {IDX_W{1'b0}};
            end else begin
                busy_r  <= busy_nxt_s;
                count_r <= count_nxt_s;
                if (load_s) begin
                    disp_valid_r <= win_found_s;
                    if (win_found_s) begin
                        disp_idx_r <= win_idx_s;
                        rr_ptr_r   <= win_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
                    end else begin
                        disp_idx_r <= disp_idx_r;
                        rr_ptr_r   <= rr_ptr_r;
                    end
                end else begin
                    // EX is stalling: the slot and the pointer hold.
                    disp_valid_r <= disp_valid_r;
                    disp_idx_r   <= disp_idx_r;
                    rr_ptr_r     <= rr_ptr_r;
                end
            end
        end else begin
            busy_r       <= busy_r;
            count_r      <= count_r;
            disp_valid_r <= disp_valid_r;
            disp_idx_r   <= disp_idx_r;
            rr_ptr_r     <= rr_ptr_r;
        end
    end

    assign alloc_ok   = alloc_ok_s;
    assign alloc_idx  = alloc_idx_s;
    assign disp_valid = disp_valid_r;
    assign disp_idx   = disp_idx_r;
    assign busy_vec   = busy_r;
    assign count      = count_r;
    assign full       = (count_r == FULL_CNT);

endmodule

// File: tb/tb_rs_sched.sv
// Self-checking bench for rs_sched: directed scenarios plus randomized traffic,
// compared against a behavioural model of the RS (bit array, modular scan).
module tb_rs_sched;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         alloc_req;
    logic         alloc_ok;
    logic [W-1:0] alloc_idx;
    logic [N-1:0] ready_vec;
    logic         ex_ready;
    logic         disp_valid;
    logic [W-1:0] disp_idx;
    logic         flush;
    logic [N-1:0] busy_vec;
    logic [W:0]   count;
    logic         full;

    rs_sched #(.RS_SIZE(N), .IDX_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .alloc_req  (alloc_req),
        .alloc_ok   (alloc_ok),
        .alloc_idx  (alloc_idx),
        .ready_vec  (ready_vec),
        .ex_ready   (ex_ready),
        .disp_valid (disp_valid),
        .disp_idx   (disp_idx),
        .flush      (flush),
        .busy_vec   (busy_vec),
        .count      (count),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_busy[N];
    bit m_dv;
    int m_didx;
    int m_rr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic logic [N-1:0] m_busy_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_dv = 1'b0;
        m_didx = 0;
        m_rr = 0;
    endtask

    // One cycle: drive inputs at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input logic r, input logic a, input logic [N-1:0] rv,
                        input logic er, input logic fl);
        bit aok;
        int fi;
        int win;
        int j;
        rdy = r; alloc_req = a; ready_vec = rv; ex_ready = er; flush = fl;
        #1;
        aok = (m_count() < N) && r && !fl;
        fi  = m_lowest_free();
        check("alloc_ok",   alloc_ok,   aok);
        check("alloc_idx",  alloc_idx,  fi);
        check("full",       full,       m_count() == N);
        check("busy_vec",   busy_vec,   m_busy_vec());
        check("count",      count,      m_count());
        check("disp_valid", disp_valid, m_dv);
        if (m_dv) check("disp_idx", disp_idx, m_didx);
        @(posedge clk);
        if (r) begin
            if (fl) begin
                for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
                m_dv = 1'b0;
                m_rr = 0;
            end else begin
                if (!m_dv || er) begin
                    win = -1;
                    for (int k = 0; k < N; k++) begin
                        j = (m_rr + k) % N;
                        if (win < 0 && m_busy[j] && rv[j]) win = j;
                    end
                    if (win >= 0) begin
                        m_dv = 1'b1;
                        m_didx = win;
                        m_busy[win] = 1'b0;
                        m_rr = (win + 1) % N;
                    end else begin
                        m_dv = 1'b0;
                    end
                end
                if (a && aok) m_busy[fi] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        check("arst_busy",  busy_vec,   16'h0000);
        check("arst_count", count,      5'd0);
        check("arst_dv",    disp_valid, 1'b0);
        check("arst_idx",   disp_idx,   4'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rv;
        rst = 1'b0; rdy = 1'b0; alloc_req = 1'b0; ready_vec = '0; ex_ready = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        check("rst_busy",  busy_vec,   16'h0000);
        check("rst_count", count,      5'd0);
        check("rst_dv",    disp_valid, 1'b0);
        check("rst_idx",   disp_idx,   4'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: three allocations, nothing ready
        repeat (3) step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        check("t1_busy",  busy_vec,   16'h0007);
        check("t1_count", count,      5'd3);
        check("t1_dv",    disp_valid, 1'b0);

        // 2: entries 1 and 2 ready, dispatched in order
        step(1'b1, 1'b0, 16'h0006, 1'b1, 1'b0);
        check("t2_idx1", disp_idx, 4'd1);
        step(1'b1, 1'b0, 16'h0006, 1'b1, 1'b0);
        check("t2_idx2", disp_idx, 4'd2);
        check("t2_busy", busy_vec, 16'h0001);

        // 3: slot holding entry 5 under EX backpressure
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0020, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        check("t3_idx",   disp_idx,   4'd5);
        check("t3_dv",    disp_valid, 1'b1);
        check("t3_busy",  busy_vec,   16'h001F);
        check("t3_count", count,      5'd5);

        // 4: fill completely, then a dispatch frees entry 0
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (16) step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        check("t4_full",  full,     1'b1);
        check("t4_aok",   alloc_ok, 1'b0);
        step(1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        check("t4_aidx",  alloc_idx, 4'd0);
        check("t4_aok2",  alloc_ok,  1'b1);
        check("t4_full2", full,      1'b0);

        // 5: pointer at 15, grants wrap 15, 0, 1; alloc + dispatch keeps count
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (16) step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h4000, 1'b1, 1'b0);
        check("t5_idx14", disp_idx, 4'd14);
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("t5_idx15", disp_idx, 4'd15);
        check("t5_count", count,    5'd15);
        step(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        check("t5_idx0",  disp_idx, 4'd0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        check("t5_idx1",  disp_idx, 4'd1);

        // 6: flush overrides alloc/dispatch; rdy=0 freezes everything
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        check("t6_busy",  busy_vec,   16'h0000);
        check("t6_count", count,      5'd0);
        check("t6_dv",    disp_valid, 1'b0);
        repeat (2) step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        check("t6_frz_busy",  busy_vec,   16'h0002);
        check("t6_frz_count", count,      5'd1);
        check("t6_frz_dv",    disp_valid, 1'b1);
        check("t6_frz_idx",   disp_idx,   4'd0);

        // Randomized traffic, including occasional async reset
        for (int n = 0; n < 3000; n++) begin
            rv = N'($urandom());
            if ($urandom_range(0, 1) == 0) rv = rv & N'($urandom());
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 8 : 4)),
                     rv,
                     ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 59) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
